// File: rtl/mm_func.sv
// mm_func: single-shot 256-bit Montgomery multiplier.
// Computes multiplier * multiplicand * 2^-256 mod modulus with 32-bit digits,
// one digit per clock. Each release of rstn starts one computation.
// Build option: define MM_FINAL_SUB_EN to include the final conditional
// subtraction (FSUB state, result < modulus, 10-edge latency). Without it the
// unreduced T (< 2*modulus) is presented after 9 edges.
// Completion: end_flag is sticky; once it is high, result is final and
// holds until the next reset. There is no other handshake.
module mm_func (
  input  logic         clk,
  input  logic         rstn,
  input  logic [255:0] multiplier,
  input  logic [255:0] multiplicand,
  input  logic [255:0] modulus,
  input  logic [31:0]  mp,
  output logic [255:0] result,
  output logic         end_flag,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_FSUB = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [255:0]   x_q, x_d;        // multiplier, shifted right one digit per CALC cycle
  logic [255:0]   y_q, y_d;
  logic [255:0]   p_q, p_d;
  logic [31:0]    mp_q, mp_d;
  logic [256:0]   t_q, t_d;        // running partial result, always < 2P for valid operands
  logic [2:0]     i_q, i_d;
  logic [255:0]   result_q, result_d;
  logic           end_flag_q, end_flag_d;

  logic [289:0]   u_sum;           // T + x_i*Y
  logic [31:0]    m_dig;           // reduction digit
  logic [289:0]   acc;             // u + m*P, low 32 bits are zero by construction
  logic [256:0]   t_next;

  // One Montgomery digit step: fold in x_i*Y, then add m*P to clear the low digit.
  always_comb begin
    u_sum  = {33'd0, t_q} + ({258'd0, x_q[31:0]} * {34'd0, y_q});
    m_dig  = u_sum[31:0] * mp_q;
    acc    = u_sum + ({258'd0, m_dig} * {34'd0, p_q});
    t_next = 257'(acc >> 32);
  end

  // Next-state and next-output logic for the LOAD/CALC/FSUB/DONE sequence.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    p_d        = p_q;
    mp_d       = mp_q;
    t_d        = t_q;
    i_d        = i_q;
    result_d   = result_q;
    end_flag_d = end_flag_q;
    unique case (state_q)
      S_LOAD: begin
        x_d     = multiplier;
        y_d     = multiplicand;
        p_d     = modulus;
        mp_d    = mp;
        t_d     = '0;
        i_d     = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        t_d = t_next;
        x_d = x_q >> 32;
        i_d = i_q + 3'd1;
        if (i_q == 3'd7) begin
`ifdef MM_FINAL_SUB_EN
          state_d    = S_FSUB;
`else
          state_d    = S_DONE;
          result_d   = t_next[255:0];
          end_flag_d = 1'b1;
`endif
        end
      end
`ifdef MM_FINAL_SUB_EN
      S_FSUB: begin
        if (t_q >= {1'b0, p_q}) result_d = 256'(t_q - {1'b0, p_q});
        else                    result_d = t_q[255:0];
        end_flag_d = 1'b1;
        state_d    = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_LOAD;
      x_q        <= '0;
      y_q        <= '0;
      p_q        <= '0;
      mp_q       <= '0;
      t_q        <= '0;
      i_q        <= '0;
      result_q   <= '0;
      end_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      p_q        <= p_d;
      mp_q       <= mp_d;
      t_q        <= t_d;
      i_q        <= i_d;
      result_q   <= result_d;
      end_flag_q <= end_flag_d;
    end
  end

  assign result    = result_q;
  assign end_flag  = end_flag_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mm_func.sv
// tb_mm_func: randomized scoreboard bench for mm_func.
// Reference model is whole-number Montgomery reduction (REDC) on 512-bit
// values; a second check confirms result*2^256 == X*Y (mod P).
// Adapts to the MM_FINAL_SUB_EN build option.
module tb_mm_func;

`ifdef MM_FINAL_SUB_EN
  localparam int LAT = 10;
  localparam bit SUB = 1'b1;
`else
  localparam int LAT = 9;
  localparam bit SUB = 1'b0;
`endif

  localparam logic [255:0] P_BIG =
    256'd16798108731015832284940804142231733909889187121439069848933715426072753864723;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [255:0] multiplier = '0;
  logic [255:0] multiplicand = '0;
  logic [255:0] modulus = '0;
  logic [31:0]  mp = '0;
  logic [255:0] result;
  logic         end_flag;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  mm_func dut (
    .clk          (clk),
    .rstn         (rstn),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .modulus      (modulus),
    .mp           (mp),
    .result       (result),
    .end_flag     (end_flag),
    .dbg_state    (dbg_state)
  );

  // ---------------- counters / scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  bit end_seen = 1'b0;
  logic [255:0] held = '0;

  logic [255:0] exp_q[$];
  logic [255:0] mod_q[$];
  logic [255:0] res_q[$];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [255:0] neg_inv(input logic [255:0] p);
    logic [255:0] inv;
    inv = p;
    for (int k = 0; k < 8; k++) inv = inv * (256'd2 - p * inv);
    return 256'd0 - inv;
  endfunction

  function automatic logic [255:0] mont_model(input logic [255:0] x, input logic [255:0] y,
                                              input logic [255:0] p);
    logic [511:0] xy;
    logic [255:0] mm;
    logic [512:0] s;
    logic [512:0] t;
    xy = {256'd0, x} * {256'd0, y};
    mm = xy[255:0] * neg_inv(p);
    s  = {1'b0, xy} + ({257'd0, mm} * {257'd0, p});
    t  = s >> 256;
    if (SUB && t >= {257'd0, p}) t = t - {257'd0, p};
    return t[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // ---------------- edge counter since release ----------------
  always @(posedge clk or negedge rstn) begin
    if (!rstn) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      end_seen <= 1'b0;
    end else if (end_flag && !end_seen) begin
      end_seen <= 1'b1;
      held     <= result;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_end: end_flag rose with no expected result, result %h", result);
      end else begin
        logic [255:0] e, p, r;
        logic [511:0] lhs;
        logic [255:0] bound;
        e = exp_q.pop_front();
        p = mod_q.pop_front();
        r = res_q.pop_front();
        check("result", result, e);
        check("latency", 256'(edge_cnt), 256'(LAT));
        lhs = {result, 256'd0} % {256'd0, p};
        check("congruence", lhs[255:0], r);
        bound = SUB ? p : (p << 1);
        check("range", 256'(result < bound), 256'd1);
      end
    end else if (end_flag && end_seen) begin
      check("hold", result, held);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input logic [255:0] x, input logic [255:0] y, input logic [255:0] p);
    @(negedge clk);
    #1;
    rstn         = 1'b0;
    multiplier   = x;
    multiplicand = y;
    modulus      = p;
    mp           = neg_inv(p)[31:0];
    #1;
    check("rst_result", result, 256'd0);
    check("rst_end_flag", 256'(end_flag), 256'd0);
    check("rst_state", 256'(dbg_state), 256'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic run_mul(input logic [255:0] x, input logic [255:0] y, input logic [255:0] p,
                         input bit change_inputs);
    logic [511:0] xy_mod;
    apply_reset(x, y, p);
    xy_mod = ({256'd0, x} * {256'd0, y}) % {256'd0, p};
    exp_q.push_back(mont_model(x, y, p));
    mod_q.push_back(p);
    res_q.push_back(xy_mod[255:0]);
    rstn = 1'b1;
    if (change_inputs) begin
      @(posedge clk);
      #1;
      multiplier   = rand256();
      multiplicand = rand256();
      modulus      = rand256() | 256'd1;
      mp           = $urandom();
    end
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      #1;
      if (end_seen) break;
    end
    if (!end_seen) begin
      n_checks++;
      $display("FAIL timeout: end_flag not seen within %0d cycles, end_flag %0b", LAT + 6, end_flag);
      exp_q.delete();
      mod_q.delete();
      res_q.delete();
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Release, then reset asynchronously in the middle of cycle 5 (CALC).
  task automatic abort_mid_calc(input logic [255:0] x, input logic [255:0] y, input logic [255:0] p);
    apply_reset(x, y, p);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_result", result, 256'd0);
    check("abort_end_flag", 256'(end_flag), 256'd0);
    check("abort_state", 256'(dbg_state), 256'd0);
  endtask

  // Reset asynchronously while holding a finished result.
  task automatic reset_in_done();
    #2;
    rstn = 1'b0;
    #1;
    check("done_rst_result", result, 256'd0);
    check("done_rst_end_flag", 256'(end_flag), 256'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] x, y;
    // directed small-modulus cases
    run_mul(256'd2, 256'd3, 256'd7, 1'b0);
    if (SUB) check("p7_2x3", result, 256'd3);
    run_mul(256'd6, 256'd6, 256'd7, 1'b0);
    if (SUB) check("p7_6x6", result, 256'd4);
    reset_in_done();
    run_mul(256'd1, 256'd2, 256'd7, 1'b0);
    if (SUB) check("p7_1x2", result, 256'd1);
    run_mul(256'd0, 256'd5, 256'd7, 1'b0);
    check("p7_0x5", result, 256'd0);
    // inputs changed after LOAD must not matter
    run_mul(256'd2, 256'd3, 256'd7, 1'b1);
    // abort during CALC, then a full run after re-release
    abort_mid_calc(256'd6, 256'd5, 256'd7);
    run_mul(256'd6, 256'd5, 256'd7, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_mul(256'($urandom_range(0, 6)), 256'($urandom_range(0, 6)), 256'd7, 1'b0);
    end
    // 256-bit modulus
    run_mul(256'd2, 256'd3, P_BIG, 1'b0);
    abort_mid_calc(rand256() % P_BIG, rand256() % P_BIG, P_BIG);
    run_mul(P_BIG - 256'd1, P_BIG - 256'd1, P_BIG, 1'b1);
    for (int n = 0; n < 100; n++) begin
      x = rand256() % P_BIG;
      y = rand256() % P_BIG;
      run_mul(x, y, P_BIG, (n % 10) == 0);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover: %0d expected results never observed", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mm_func.md
# mm_func

Single-shot 256-bit Montgomery modular multiplier. It computes multiplier·multiplicand·2^-256 mod modulus using word-serial Montgomery reduction with 32-bit digits, one digit per clock. It is the core arithmetic primitive beneath the modular-exponentiation/ECC datapath. A computation starts automatically when reset is released, and completion is flagged with a sticky `end_flag`.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rstn`).

No parameters. Operand width 256 and digit width 32 are fixed.

- `clk` in 1 — rising-edge clock.
- `rstn` in 1 — asynchronous, active-low reset; also the restart mechanism.
- `multiplier` in 256 — operand X; requires X < modulus.
- `multiplicand` in 256 — operand Y; requires Y < modulus.
- `modulus` in 256 — P; must be odd and < 2^255.
- `mp` in 32 — P' = −P⁻¹ mod 2^32, precomputed by the caller.
- `result` out 256 — Z = X·Y·2^-256 mod P; registered.
- `end_flag` out 1 — high once `result` is valid; sticky until reset.

## Operation
- States: LOAD → CALC → FSUB → DONE.
- Reset: state = LOAD; T, i, `result`, and `end_flag` are all 0.
- LOAD (first rising edge after `rstn` rises):
  - Capture X, Y, P, and P' into internal registers.
  - Set T = 0 and i = 0.
  - Move to CALC.
  - Input changes after this edge are ignored.
- CALC (8 cycles, i = 0..7). Each cycle, with x_i = X[32i+31:32i]:
  - u = T + x_i·Y
  - m = (u[31:0]·P') mod 2^32
  - T ← (u + m·P) >> 32
  - i ← i+1
  - After i = 7, go to FSUB.
- CALC widths:
  - T is 257 bits.
  - The intermediate sum is at least 290 bits wide.
  - The low 32 bits of u + m·P are always zero, by construction.
- FSUB (1 cycle):
  - `result` ← (T ≥ P) ? T − P : T[255:0].
  - `end_flag` ← 1.
  - Go to DONE.
- DONE: hold `result` and `end_flag`. No further operation until the next reset.
- Preconditions:
  - Invariant: T < 2P at every step.
  - If X ≥ P, Y ≥ P, P is even, or P' is wrong, `result` is unspecified. The block must still reach DONE on schedule.
- Reset mid-operation: aborts immediately. All outputs return to reset values, and a fresh LOAD follows release.

## Timing
- Cycle 1 after `rstn` release: LOAD.
- Cycles 2–9: CALC.
- Cycle 10: FSUB. `result`/`end_flag` update on the 10th rising edge after release.
- `end_flag` rises in the same edge as the final `result`; `result` is never observed changing while `end_flag` = 1.
- Throughput: one multiplication per reset pulse.
- Full 32×256 multiply-accumulate per cycle, purely combinational between registers.

## Configuration
- `MM_FINAL_SUB_EN` defined:
  - FSUB state exists as described.
  - `result` < P.
  - Latency is 10 edges.
- Undefined:
  - FSUB is removed; CALC goes directly to DONE.
  - `result` = T[255:0] (unreduced, < 2P).
  - `end_flag` asserts on the 9th rising edge after release.

## Test plan
All scenarios use P = 7, P' = 0x49249249, where 2^-256 ≡ 4 (mod 7), unless stated otherwise.

- X = 2, Y = 3 → `result` = 3; `end_flag` rises exactly 10 edges after `rstn` release.
- X = 6, Y = 6 → `result` = 4.
- X = 1, Y = 2 (R mod 7) → `result` = 1; X = 0, Y = 5 → `result` = 0.
- 256-bit P = 16798108731015832284940804142231733909889187121439069848933715426072753864723, with P' computed as −P⁻¹ mod 2^32:
  - X = 2, Y = 3 → `result` equals the reference model 6·2^-256 mod P.
  - Also run 100 random X, Y < P → all match the model.
- Reset behaviour:
  - Change inputs after LOAD → `result` unaffected.
  - Assert `rstn` during CALC (cycle 5) → `result` = 0 and `end_flag` = 0 immediately (asynchronously).
  - After re-release, the new result arrives 10 edges later.
- Build without `MM_FINAL_SUB_EN`, X = 2, Y = 3, P = 7 → `end_flag` at edge 9; `result` ≡ 3 (mod 7) and < 14.
